// File: rtl/mtr_duty_ramp.sv
// Slew-limited duty feeder for the left/right motor PWM generators; duty moves only on the PWM period wrap.
// Optional build macro DUTY_DEADBAND_EN snaps small speed commands (|spd| < DEADBAND) to the stop duty.
module mtr_duty_ramp #(
  parameter int STEP     = 16,
  parameter int DEADBAND = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  input  logic        spd_vld,
  input  logic        brake,
  output logic [10:0] lft_duty,
  output logic [10:0] rght_duty,
  output logic        upd,
  output logic        at_target
);

  localparam logic [10:0] MID    = 11'h400;
  localparam logic [11:0] STEP_W = 12'(STEP);

  if (STEP < 1 || STEP > 1023 || DEADBAND < 0) begin : g_param_chk
    $error("mtr_duty_ramp: STEP must be 1..1023 and DEADBAND non-negative");
  end

  logic [10:0] r_cnt;
  logic        r_upd;
  logic [10:0] r_lft_tgt;
  logic [10:0] r_rght_tgt;
  logic [10:0] r_lft_duty;
  logic [10:0] r_rght_duty;
  logic        r_at_tgt;

  logic        w_tick;
  logic [10:0] w_lft_new_tgt;
  logic [10:0] w_rght_new_tgt;
  logic [10:0] w_lft_next_duty;
  logic [10:0] w_rght_next_duty;

  // -1024 has no positive twin, so clip it to keep the target inside 1..2047.
  function automatic logic [10:0] spd_to_tgt(input logic [10:0] spd);
    logic [10:0] sat;
`ifdef DUTY_DEADBAND_EN
    logic [10:0] mag;
`endif
    sat = (spd == 11'h400) ? 11'h401 : spd;
`ifdef DUTY_DEADBAND_EN
    mag = sat[10] ? (~sat + 11'd1) : sat;
    if (mag < 11'(DEADBAND)) sat = '0;
`endif
    return MID + sat;
  endfunction

  function automatic logic [10:0] ramp(input logic [10:0] duty, input logic [10:0] tgt);
    logic [11:0] diff;
    logic [11:0] mag;
    diff = {1'b0, tgt} - {1'b0, duty};
    mag  = diff[11] ? (~diff + 12'd1) : diff;
    if (mag <= STEP_W)  return tgt;
    else if (!diff[11]) return duty + STEP_W[10:0];
    else                return duty - STEP_W[10:0];
  endfunction

  assign w_tick           = (r_cnt == 11'h7FF);
  assign w_lft_new_tgt    = spd_to_tgt(lft_spd);
  assign w_rght_new_tgt   = spd_to_tgt(rght_spd);
  assign w_lft_next_duty  = ramp(r_lft_duty, r_lft_tgt);
  assign w_rght_next_duty = ramp(r_rght_duty, r_rght_tgt);

  // Ramp uses the pre-edge targets, so a capture on the tick edge applies from the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_upd       <= 1'b0;
      r_lft_tgt   <= MID;
      r_rght_tgt  <= MID;
      r_lft_duty  <= MID;
      r_rght_duty <= MID;
      r_at_tgt    <= 1'b1;
    end else begin
      r_cnt    <= r_cnt + 11'd1;
      r_upd    <= w_tick;
      r_at_tgt <= (r_lft_duty == r_lft_tgt) && (r_rght_duty == r_rght_tgt);
      if (brake) begin
        r_lft_tgt  <= MID;
        r_rght_tgt <= MID;
      end else if (spd_vld) begin
        r_lft_tgt  <= w_lft_new_tgt;
        r_rght_tgt <= w_rght_new_tgt;
      end
      if (w_tick) begin
        r_lft_duty  <= w_lft_next_duty;
        r_rght_duty <= w_rght_next_duty;
      end
    end
  end

  assign lft_duty  = r_lft_duty;
  assign rght_duty = r_rght_duty;
  assign upd       = r_upd;
  assign at_target = r_at_tgt;

endmodule

// File: doc/mtr_duty_ramp.md
Name: mtr_duty_ramp

Overview:
- Upstream feeder for the two 11-bit PWM generators of the left and right motor H-bridges.
- Accepts signed left/right speed commands, saturates them and offsets them to unsigned duty (0x400 = stopped).
- Slew-limits each duty by at most STEP per PWM period.
- Updates duty only on the PWM period boundary, so the PWM stage never sees a mid-period change.

Parameters:
- STEP, 16, max duty change per update tick; legal range 1..1023.
- DEADBAND, 8, half-width of the zero-speed snap window. Used only with DUTY_DEADBAND_EN.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- lft_spd  input  11  signed left speed command, two's complement.
- rght_spd  input  11  signed right speed command, two's complement.
- spd_vld  input  1  single-cycle strobe; capture lft_spd/rght_spd as new targets.
- brake  input  1  level; forces both targets to 0x400 (stop) while high.
- lft_duty  output  11  unsigned duty to the left PWM generator.
- rght_duty  output  11  unsigned duty to the right PWM generator.
- upd  output  1  one-cycle pulse on the cycle after duty registers are evaluated.
- at_target  output  1  high when both duties equal their targets.

Behaviour:
- Clock/reset: clk, with rst_n asynchronous, active-low, as already decided.
- Reset values: period counter = 0; lft_tgt = rght_tgt = 0x400; lft_duty = rght_duty = 0x400; upd = 0; at_target = 1.
- Period counter: 11-bit, counts 0..2047 and wraps, incrementing every clk. It is phase-aligned with the PWM generators' counter because both come out of the same reset.
- tick = (cnt == 2047). At that edge the duty registers load their new value, so the new duty is first compared at PWM count 0.
- upd = 1 during the cycle where cnt == 0, i.e. registered tick.
- Target capture (spd_vld = 1 and brake = 0):
  - Saturate: speed -1024 clips to -1023; all other values pass unchanged.
  - tgt = 0x400 + sat_spd, 11-bit unsigned, range 1..2047.
- Brake: while brake = 1, both tgt registers load 0x400 every cycle and spd_vld is ignored. On brake release, tgt stays 0x400 until the next spd_vld.
- Ramp, on each tick and per side independently:
  - diff = tgt - duty, computed in 12-bit signed.
  - If |diff| <= STEP then duty = tgt.
  - Else if diff > 0 then duty = duty + STEP.
  - Else duty = duty - STEP.
  - Duty never leaves 1..2047 and never overshoots tgt.
- Simultaneous spd_vld and tick: the tick ramps toward the pre-edge tgt. The new tgt is captured on the same edge and applies from the next tick.
- Simultaneous brake and tick: same rule; the tick uses the pre-edge tgt.
- Multiple spd_vld within one period: the last one wins.
- at_target: registered compare (lft_duty == lft_tgt) && (rght_duty == rght_tgt), one-cycle latency after either side changes.
- Reset mid-ramp: all state returns to reset values immediately; no partial step survives.
- Between ticks, lft_duty and rght_duty are stable by construction.

Optional Feature:
- Macro: DUTY_DEADBAND_EN
- Defined: during target capture, a saturated speed with |sat_spd| < DEADBAND is treated as 0, giving tgt = 0x400. With DEADBAND = 8, speeds -7..+7 map to 0x400 and -8/+8 pass through.
- Undefined: no deadband logic is compiled; every speed maps linearly. The DEADBAND parameter exists but is unused.

Test Plan:
- Reset release, no commands, 3 periods -> lft_duty = rght_duty = 0x400; at_target = 1; upd pulses exactly at cnt == 0 every 2048 clks.
- spd_vld with lft_spd = +100, rght_spd = -100, STEP = 16:
  - Left steps 0x410, 0x420, ... 0x460, then 0x464 on the 7th tick.
  - Right mirrors down to 0x39C.
  - at_target rises one cycle after the 7th tick.
  - Duty outputs change only at cnt 2047 -> 0.
- Saturation: lft_spd = -1024 (0x400) -> tgt = 0x001; after 64 ticks lft_duty = 0x001; rght_spd = +1023 -> final duty 0x7FF; no wrap-around.
- Brake mid-ramp: brake asserted at duty 0x460 toward 0x600 -> duty ramps down by 16/tick to 0x400. spd_vld pulses during brake are ignored.
- spd_vld on the same cycle as tick (cnt = 2047), old tgt 0x500, new speed 0 -> that tick steps toward 0x500; subsequent ticks step toward 0x400.
- DUTY_DEADBAND_EN defined, DEADBAND = 8:
  - speed +7 -> tgt 0x400; speed +8 -> tgt 0x408; speed -7 -> tgt 0x400.
  - With the macro undefined, speed +7 -> tgt 0x407.
